// File: rtl/vector_dot_pkg.sv
// Shared types and constants for the vector dot-product feeder and its engine.
package vector_dot_pkg;

  localparam int VD_ADDR_W  = 2;
  localparam int VD_MAX_LEN = 4;

  localparam logic VD_SEL_A = 1'b0;
  localparam logic VD_SEL_B = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    A_REQ,
    A_WAIT,
    A_WR,
    B_REQ,
    B_WAIT,
    B_WR,
    FLUSH,
    RD_REQ,
    RD_CAP,
    DONE
  } vd_state_e;

endpackage

// File: rtl/vector_dot_mem_rd.sv
// Single-outstanding Avalon-MM read requester with a data capture register.
// Optional watchdog enabled by VECTOR_DOT_FEEDER_TIMEOUT_EN.
module vector_dot_mem_rd
`ifdef VECTOR_DOT_FEEDER_TIMEOUT_EN
  #(parameter int TIMEOUT_CYC = 255)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic        rd_wait,
  input  logic [31:0] rd_addr,
  output logic        rd_accept,
  output logic        rd_vld,
  output logic [31:0] rd_data,
  output logic        rd_timeout,
  output logic [31:0] m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid
);

  // rd_addr is held by the caller for the whole request, so the address is stable across stalls
  assign m_read    = rd_req & ~rd_timeout;
  assign m_address = m_read ? rd_addr : '0;
  assign rd_accept = m_read & ~m_waitrequest;
  // a valid outside the wait phase belongs to an abandoned read and is dropped
  assign rd_vld    = rd_wait & m_readdatavalid & ~rd_timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       rd_data <= '0;
    else if (rd_vld) rd_data <= m_readdata;
  end

`ifdef VECTOR_DOT_FEEDER_TIMEOUT_EN
  logic [7:0] to_cnt;

  // restarts on every request/wait phase change
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                             to_cnt <= '0;
    else if (!(rd_req | rd_wait) || rd_accept || rd_vld)   to_cnt <= '0;
    else                                                   to_cnt <= to_cnt + 8'd1;
  end

  assign rd_timeout = (rd_req | rd_wait) && (to_cnt == 8'(TIMEOUT_CYC));
`else
  assign rd_timeout = 1'b0;
`endif

endmodule

// File: rtl/vector_dot_feeder.sv
// Fetches vectors A and B from memory, feeds the dot-product engine, returns the result.
// Optional memory watchdog enabled by VECTOR_DOT_FEEDER_TIMEOUT_EN.
module vector_dot_feeder
  import vector_dot_pkg::*;
#(
  parameter int MAX_LEN     = VD_MAX_LEN,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_a,
  input  logic [31:0] base_b,
  input  logic [2:0]  len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result,
  output logic [31:0] m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic [1:0]  dot_address,
  output logic [31:0] dot_writedata,
  output logic        dot_write,
  output logic        dot_read,
  output logic        dot_b_data,
  input  logic [31:0] dot_readdata
);

  if (MAX_LEN < 1 || MAX_LEN > VD_MAX_LEN || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_cfg_chk
    $error("vector_dot_feeder: MAX_LEN or TIMEOUT_CYC out of range");
  end

  vd_state_e   state, nxt;
  logic [31:0] base_a_q, base_b_q, rd_addr, rd_data;
  logic [2:0]  len_q, idx, idx_inc;
  logic        last, bad_len, rd_req, rd_wait, in_b, wr_phase;
  logic        rd_accept, rd_vld, rd_timeout;

  assign idx_inc  = idx + 3'd1;
  assign last     = (idx_inc == len_q);
  assign bad_len  = (len == 3'd0) || (32'(len) > 32'(MAX_LEN));
  assign rd_req   = (state == A_REQ)  || (state == B_REQ);
  assign rd_wait  = (state == A_WAIT) || (state == B_WAIT);
  assign in_b     = (state == B_REQ)  || (state == B_WAIT);
  assign wr_phase = (state == A_WR)   || (state == B_WR);
  assign rd_addr  = (in_b ? base_b_q : base_a_q) + {27'd0, idx, 2'b00};

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign dot_address   = wr_phase ? idx[VD_ADDR_W-1:0] : '0;
  assign dot_writedata = wr_phase ? rd_data : '0;

  vector_dot_mem_rd
`ifdef VECTOR_DOT_FEEDER_TIMEOUT_EN
    #(.TIMEOUT_CYC(TIMEOUT_CYC))
`endif
  u_mem_rd (
    .clk             (clk),
    .reset           (reset),
    .rd_req          (rd_req),
    .rd_wait         (rd_wait),
    .rd_addr         (rd_addr),
    .rd_accept       (rd_accept),
    .rd_vld          (rd_vld),
    .rd_data         (rd_data),
    .rd_timeout      (rd_timeout),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid)
  );

  // A bad length detours through RD_CAP (err blocks the capture) so done lands 2 cycles after start
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = bad_len ? RD_CAP : A_REQ;
      A_REQ:   if (rd_timeout) nxt = DONE; else if (rd_accept) nxt = A_WAIT;
      A_WAIT:  if (rd_timeout) nxt = DONE; else if (rd_vld)    nxt = A_WR;
      A_WR:    nxt = last ? B_REQ : A_REQ;
      B_REQ:   if (rd_timeout) nxt = DONE; else if (rd_accept) nxt = B_WAIT;
      B_WAIT:  if (rd_timeout) nxt = DONE; else if (rd_vld)    nxt = B_WR;
      B_WR:    nxt = last ? FLUSH : B_REQ;
      FLUSH:   nxt = RD_REQ;
      RD_REQ:  nxt = RD_CAP;
      RD_CAP:  nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      base_a_q   <= '0;
      base_b_q   <= '0;
      len_q      <= '0;
      idx        <= '0;
      err        <= 1'b0;
      result     <= '0;
      dot_write  <= 1'b0;
      dot_read   <= 1'b0;
      dot_b_data <= VD_SEL_A;
    end else begin
      state      <= nxt;
      // strobes decoded from the next state so they line up with the state they belong to
      dot_write  <= (nxt == A_WR) || (nxt == B_WR) || (nxt == FLUSH);
      dot_read   <= (nxt == RD_REQ);
      dot_b_data <= ((nxt == B_WR) || (nxt == FLUSH)) ? VD_SEL_B : VD_SEL_A;
      unique case (state)
        IDLE: if (start) begin
          if (bad_len) begin
            err    <= 1'b1;
            result <= '0;
          end else begin
            base_a_q <= base_a;
            base_b_q <= base_b;
            len_q    <= len;
            idx      <= '0;
            err      <= 1'b0;
          end
        end
        A_WR:    idx <= last ? 3'd0 : idx_inc;
        B_WR:    idx <= idx_inc;
        RD_CAP:  if (!err) result <= dot_readdata;
        default: ;
      endcase
      if ((rd_req || rd_wait) && rd_timeout) begin
        err    <= 1'b1;
        result <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vector_dot_feeder.sv
// Directed bench: memory responder, behavioural dot engine, hand-computed expectations.
module tb_vector_dot_feeder;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] base_a = '0, base_b = '0;
  logic [2:0]  len = '0;
  logic        busy, done, err;
  logic [31:0] result, m_address, m_readdata, dot_writedata, dot_readdata;
  logic        m_read, m_waitrequest, m_readdatavalid;
  logic [1:0]  dot_address;
  logic        dot_write, dot_read, dot_b_data;

  vector_dot_feeder dut (
    .clk(clk), .reset(reset), .start(start), .base_a(base_a), .base_b(base_b), .len(len),
    .busy(busy), .done(done), .err(err), .result(result),
    .m_address(m_address), .m_read(m_read), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .dot_address(dot_address), .dot_writedata(dot_writedata), .dot_write(dot_write),
    .dot_read(dot_read), .dot_b_data(dot_b_data), .dot_readdata(dot_readdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // single-precision <-> real through the double layout (normal values and zero only)
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'({3'd0, f[30:23]}) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // memory: one word per 4-byte address, read data one cycle after acceptance
  logic [31:0] mem [logic [31:0]];
  logic        stall_en = 1'b0, no_rv = 1'b0;
  initial begin
    logic        acc, prev_stall;
    logic [31:0] acc_addr, prev_addr;
    int          wcnt;
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
    prev_stall = 1'b0; prev_addr = '0; wcnt = 0;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        chk("stall_read_held", {31'd0, m_read}, 32'd1);
        chk("stall_addr_stable", m_address, prev_addr);
      end
      prev_stall = m_read && m_waitrequest;
      prev_addr  = m_address;
      acc        = m_read && !m_waitrequest;
      acc_addr   = m_address;
      @(posedge clk);
      #1;
      m_readdatavalid = acc && !no_rv;
      m_readdata      = acc ? mem[acc_addr] : 32'd0;
      if (stall_en && wcnt < 3 && $urandom_range(0, 1) == 1) begin
        m_waitrequest = 1'b1; wcnt++;
      end else begin
        m_waitrequest = 1'b0; wcnt = 0;
      end
    end
  end

  // engine: stores A; each B write accumulates the previous product, read returns and clears
  initial begin
    real ea [4];
    real eacc, epend;
    dot_readdata = '0; eacc = 0.0; epend = 0.0;
    for (int i = 0; i < 4; i++) ea[i] = 0.0;
    forever begin
      @(negedge clk);
      if (reset) begin
        eacc = 0.0; epend = 0.0;
      end else begin
        if (dot_write) begin
          if (!dot_b_data) ea[dot_address] = f2r(dot_writedata);
          else begin
            eacc  = eacc + epend;
            epend = ea[dot_address] * f2r(dot_writedata);
          end
        end
        if (dot_read) begin
          dot_readdata = r2f(eacc);
          eacc = 0.0; epend = 0.0;
        end
      end
    end
  end

  // bus activity counters
  int n_mr = 0, n_dw = 0, n_bw = 0, n_dr = 0, n_both = 0;
  logic [31:0] last_bw_data = '0;
  logic [1:0]  last_bw_addr = '0;
  initial forever begin
    @(negedge clk);
    if (m_read) n_mr++;
    if (dot_write) n_dw++;
    if (dot_read) n_dr++;
    if (dot_write && dot_read) n_both++;
    if (dot_write && dot_b_data) begin
      n_bw++; last_bw_data = dot_writedata; last_bw_addr = dot_address;
    end
  end

  int s_mr, s_dw, s_bw, s_dr;
  task automatic run(input logic [2:0] l, input logic [31:0] ba, input logic [31:0] bb,
                     input logic [31:0] exp_res, input logic exp_err, input int exp_cyc);
    int cyc;
    s_mr = n_mr; s_dw = n_dw; s_bw = n_bw; s_dr = n_dr;
    len = l; base_a = ba; base_b = bb; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk); cyc++;
      if (done) break;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    if (exp_cyc > 0) chk("latency", cyc, exp_cyc);
    chk("result", result, exp_res);
    chk("err", {31'd0, err}, {31'd0, exp_err});
    @(negedge clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mem[32'h100] = 32'h3F800000; mem[32'h104] = 32'h40000000; mem[32'h108] = 32'h40400000;
    mem[32'h200] = 32'h40800000; mem[32'h204] = 32'h40A00000; mem[32'h208] = 32'h40C00000;
    mem[32'h300] = 32'h40000000; mem[32'h310] = 32'hBFC00000;
    mem[32'h400] = 32'h3F800000; mem[32'h404] = 32'h40000000;
    mem[32'h408] = 32'h40400000; mem[32'h40C] = 32'h40800000;
    for (int i = 0; i < 4; i++) mem[32'h500 + 32'(4 * i)] = 32'h3F000000;

    #2;
    chk("rst_status", {28'd0, busy, done, err, m_read}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_m_address", m_address, 32'd0);
    chk("rst_dot_ctl", {27'd0, dot_write, dot_read, dot_b_data, dot_address}, 32'd0);
    chk("rst_dot_wdata", dot_writedata, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // len 3: 1*4 + 2*5 + 3*6 = 32.0
    run(3'd3, 32'h100, 32'h200, 32'h42000000, 1'b0, 22);
    chk("len3_mreads", n_mr - s_mr, 6);
    chk("len3_dwrites", n_dw - s_dw, 7);
    chk("len3_bwrites", n_bw - s_bw, 4);
    chk("len3_dreads", n_dr - s_dr, 1);

    // len 1: 2.0 * -1.5 = -3.0; second B-side write is the zero flush
    run(3'd1, 32'h300, 32'h310, 32'hC0400000, 1'b0, 10);
    chk("len1_bwrites", n_bw - s_bw, 2);
    chk("len1_flush_data", last_bw_data, 32'd0);
    chk("len1_flush_addr", {30'd0, last_bw_addr}, 32'd0);

    // len 4: 0.5 * (1+2+3+4) = 5.0, without and with stalls
    run(3'd4, 32'h400, 32'h500, 32'h40A00000, 1'b0, 28);
    stall_en = 1'b1;
    run(3'd4, 32'h400, 32'h500, 32'h40A00000, 1'b0, -1);
    chk("stall_mreads_min", {31'd0, (n_mr - s_mr) >= 8}, 32'd1);
    stall_en = 1'b0;
    @(negedge clk);

    // ignored restart mid-run, then reset in B_WAIT of element 0
    len = 3'd3; base_a = 32'h100; base_b = 32'h200; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 start = 1'b1; len = 3'd0;
    @(posedge clk); #1 start = 1'b0; len = 3'd3;
    @(negedge clk);
    chk("restart_ignored_err", {31'd0, err}, 32'd0);
    chk("restart_ignored_busy", {31'd0, busy}, 32'd1);
    repeat (6) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_status", {28'd0, busy, done, err, m_read}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_dot_ctl", {27'd0, dot_write, dot_read, dot_b_data, dot_address}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run(3'd3, 32'h100, 32'h200, 32'h42000000, 1'b0, 22);

    // bad lengths: no traffic, err, result forced to zero
    run(3'd0, 32'h100, 32'h200, 32'h00000000, 1'b1, 2);
    chk("len0_traffic", (n_mr - s_mr) + (n_dw - s_dw) + (n_dr - s_dr), 0);
    run(3'd5, 32'h100, 32'h200, 32'h00000000, 1'b1, 2);
    chk("len5_traffic", (n_mr - s_mr) + (n_dw - s_dw) + (n_dr - s_dr), 0);
    chk("never_write_and_read", n_both, 0);

`ifdef VECTOR_DOT_FEEDER_TIMEOUT_EN
    no_rv = 1'b1;
    run(3'd3, 32'h100, 32'h200, 32'h00000000, 1'b1, -1);
    no_rv = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vector_dot_feeder.md
# vector_dot_feeder

Upstream fetch-and-feed stage for the vector dot-product engine. On a start pulse, it reads vector A and then vector B from system memory through an Avalon-MM read master. It writes A into the engine's operand buffer (`b_data`=0) and streams B through the engine's multiply-accumulate path (`b_data`=1). It then issues the flush write and the result read, and presents the single-precision dot product with a done pulse.

## Interface
Parameters:
- `MAX_LEN`, 4: maximum vector length, limited by the engine's 2-bit address.
- `TIMEOUT_CYC`, 255: watchdog limit in cycles; used only with `VECTOR_DOT_FEEDER_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock shared with the engine.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; ignored unless idle.
- `base_a` in 32: byte address of A[0]; element i is at `base_a`+4i.
- `base_b` in 32: byte address of B[0].
- `len` in 3: vector length; valid range 1..`MAX_LEN`.
- `busy` out 1: high from the accepted start until done.
- `done` out 1: one-cycle pulse when the result is valid.
- `err` out 1: sticky until the next start; set on a bad `len` or a timeout.
- `result` out 32: IEEE-754 dot product, held until the next start.
- `m_address` out 32: memory read master address.
- `m_read` out 1: memory read request.
- `m_waitrequest` in 1: memory stall.
- `m_readdata` in 32: memory read data.
- `m_readdatavalid` in 1: memory read data valid.
- `dot_address` out 2: engine address.
- `dot_writedata` out 32: engine write data.
- `dot_write` out 1: engine write strobe.
- `dot_read` out 1: engine read strobe.
- `dot_b_data` out 1: engine operand select.
- `dot_readdata` in 32: engine read data.

## Operation
- FSM states: IDLE, A_REQ, A_WAIT, A_WR, B_REQ, B_WAIT, B_WR, FLUSH, RD_REQ, RD_CAP, DONE.
- IDLE + `start`:
  - If `len`==0 or `len`>`MAX_LEN`: set `err`, force `result`=0, go to DONE. No bus traffic.
  - Otherwise: latch the bases and `len`, clear the index, clear `err`, go to A_REQ.
- A_REQ / B_REQ:
  - Drive `m_read`=1 with `m_address`=base+4·idx.
  - Hold `m_read` and `m_address` stable while `m_waitrequest`=1.
  - Advance to the matching WAIT state on the first cycle with `m_waitrequest`=0.
- A_WAIT / B_WAIT: on `m_readdatavalid`, capture `m_readdata` into a data register and advance to the matching WR state.
- Only one memory read is outstanding at any time.
- A_WR:
  - Drive `dot_write`=1, `dot_b_data`=0, `dot_address`=idx, `dot_writedata`=the captured data.
  - Increment idx. If idx reaches `len`, clear idx and go to B_REQ; otherwise go to A_REQ.
- B_WR:
  - Drive the same write with `dot_b_data`=1.
  - If idx reaches `len`, go to FLUSH; otherwise go to B_REQ.
- FLUSH:
  - Drive `dot_write`=1, `dot_b_data`=1, `dot_address`=0, `dot_writedata`=0.
  - This write is required because the engine's accumulator lags one write behind, so the last product is summed only by this write.
- RD_REQ: drive `dot_read`=1 for exactly one cycle. The engine registers the result and clears itself.
- RD_CAP: `result`<=`dot_readdata`.
- DONE: `done`=1 for one cycle, `busy`=0 on the next cycle, return to IDLE.
- All `dot_*` strobes are registered. At most one of `dot_write` and `dot_read` is high in any cycle.
- A `start` pulse while busy is dropped with no side effects.

## Timing
- Reset (asynchronous): state=IDLE. Every output is 0: `busy`, `done`, `err`, `result`, `m_*`, `dot_*`.
- The engine shares `reset`, so a reset mid-operation clears both blocks consistently. Any in-flight memory read is abandoned, and a late `m_readdatavalid` in IDLE is ignored.
- With zero wait states and `m_readdatavalid` one cycle after acceptance, each element takes 3 cycles.
- Start-to-done latency is 6·`len`+4 cycles. Each `m_waitrequest` or valid-delay cycle adds one cycle.
- Bad-`len` path: `done` pulses 2 cycles after `start`.

## Configuration
- `VECTOR_DOT_FEEDER_TIMEOUT_EN` defined:
  - An 8-bit counter runs in the REQ and WAIT states and clears on each state change.
  - When it reaches `TIMEOUT_CYC`: drop `m_read`, set `err`, set `result`=0, and go to DONE. The engine is left uncleared until the next run's read.
- `VECTOR_DOT_FEEDER_TIMEOUT_EN` undefined: no counter exists, and the FSM waits on memory indefinitely.

## Structure
- Shared package `vector_dot_pkg` holds:
  - the FSM state enum;
  - `VD_ADDR_W`=2 and `VD_MAX_LEN`=4;
  - the `b_data` encodings `VD_SEL_A`=0 and `VD_SEL_B`=1.
- One sub-module, `vector_dot_mem_rd`: a single-outstanding Avalon read requester (request, waitrequest, capture, timeout). The FSM and engine sequencing stay in the top module.

## Test plan
- `len`=3, A={1.0,2.0,3.0}, B={4.0,5.0,6.0}, zero-wait memory → `result`=0x42000000 (32.0) and `done` exactly 22 cycles after `start`.
- `len`=1, A={2.0}, B={-1.5} → `result`=0xC0400000. Verify that exactly two `b_data`=1 writes occur, the second being FLUSH with data 0.
- `len`=4 with random `m_waitrequest` stalls (0–3 cycles) → same result as the no-stall run, and `m_address` is stable during every stall.
- `len`=0 and `len`=5 → `err`=1, `result`=0, `done` 2 cycles after `start`, and no `m_read` or `dot_*` activity.
- `start` re-pulsed mid-run, then `reset` asserted during B_WAIT → the second `start` is ignored. Reset clears all outputs immediately, and a fresh run afterwards gives the correct result.
- With `VECTOR_DOT_FEEDER_TIMEOUT_EN`, `m_readdatavalid` never asserted → `err`=1 and `done` at `TIMEOUT_CYC` cycles after acceptance.
